ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter. Inhibits the bus,
//                issues a request-to-send, shifts a command byte plus odd
//                parity and stop bit out on device clock edges, and checks
//                the device ACK. Includes an overall frame timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 120,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       send,
    input  logic [7:0] tx_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int ICW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ICW-1:0] INH_LAST = ICW'(INHIBIT_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     EDGE_ACK = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    state_t         state, state_next;
    logic [1:0]     clk_sync, data_sync;
    logic           clk_prev;
    logic           dev_fall;
    logic [ICW-1:0] inh_cnt, inh_cnt_next;
    logic [TCW-1:0] tmo_cnt, tmo_cnt_next;
    logic [3:0]     edge_cnt, edge_cnt_next, edge_inc;
    logic [7:0]     tx_byte, tx_byte_next;
    logic           parity, parity_next;
    logic           clk_oe_next, data_oe_next, busy_next, done_next;
    logic           ack_err_next, timeout_next;

    // Two-flop synchronizers on the raw bus lines plus a delayed clock copy
    // for falling-edge detection; lines idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    // A device falling edge: synchronized clock was 1, now 0.
    assign dev_fall = clk_prev & ~clk_sync[1];
    assign edge_inc = edge_cnt + 4'd1;

    // State, counters, frame data and all outputs are registered together so
    // every output reflects the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            edge_cnt    <= 4'd0;
            tx_byte     <= 8'h00;
            parity      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            inh_cnt     <= inh_cnt_next;
            tmo_cnt     <= tmo_cnt_next;
            edge_cnt    <= edge_cnt_next;
            tx_byte     <= tx_byte_next;
            parity      <= parity_next;
            ps2_clk_oe  <= clk_oe_next;
            ps2_data_oe <= data_oe_next;
            busy        <= busy_next;
            done        <= done_next;
            ack_err     <= ack_err_next;
            timeout     <= timeout_next;
        end
    end

    // Next-state and next-output logic; the timeout check outranks any bus
    // event in the same cycle.
    always_comb begin
        state_next    = state;
        inh_cnt_next  = inh_cnt;
        tmo_cnt_next  = tmo_cnt;
        edge_cnt_next = edge_cnt;
        tx_byte_next  = tx_byte;
        parity_next   = parity;
        clk_oe_next   = 1'b0;
        data_oe_next  = ps2_data_oe;
        done_next     = 1'b0;
        ack_err_next  = ack_err;
        timeout_next  = timeout;

        case (state)
            ST_IDLE: begin
                data_oe_next = 1'b0;
                if (send) begin
                    tx_byte_next = tx_data;
                    parity_next  = ~^tx_data;
                    ack_err_next = 1'b0;
                    timeout_next = 1'b0;
                    inh_cnt_next = '0;
                    clk_oe_next  = 1'b1;
                    state_next   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                clk_oe_next  = 1'b1;
                data_oe_next = 1'b0;
                if (inh_cnt == INH_LAST) begin
                    data_oe_next = 1'b1;
                    state_next   = ST_REQ;
                end else begin
                    inh_cnt_next = inh_cnt + 1'b1;
                end
            end

            ST_REQ: begin
                // Release the clock, keep the start bit on data.
                data_oe_next  = 1'b1;
                tmo_cnt_next  = '0;
                edge_cnt_next = 4'd0;
                state_next    = ST_XFER;
            end

            ST_XFER: begin
                if (tmo_cnt == TMO_LAST) begin
                    data_oe_next = 1'b0;
                    timeout_next = 1'b1;
                    ack_err_next = 1'b0;
                    done_next    = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                    if (dev_fall && (edge_cnt != EDGE_ACK)) begin
                        edge_cnt_next = edge_inc;
                        if (edge_inc <= 4'd8) begin
                            data_oe_next = ~tx_byte[edge_cnt[2:0]];
                        end else if (edge_inc == 4'd9) begin
                            data_oe_next = ~parity;
                        end else if (edge_inc == 4'd10) begin
                            data_oe_next = 1'b0;
                        end else begin
                            data_oe_next = 1'b0;
                            ack_err_next = data_sync[1];
                            state_next   = ST_WAIT_IDLE;
                        end
                    end
                end
            end

            ST_WAIT_IDLE: begin
                data_oe_next = 1'b0;
                if (tmo_cnt == TMO_LAST) begin
                    timeout_next = 1'b1;
                    ack_err_next = 1'b0;
                    done_next    = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                    if (clk_sync[1] && data_sync[1]) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                data_oe_next = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

endmodule
`default_nettype wire
